inv_sub_bytes_seq: RTL
======================

Name: inv_sub_bytes_seq

Overview:
- Iterative InvSubBytes stage of the AES decryption round datapath.
- Sits directly downstream of the inverse ShiftRows stage and consumes its 16-byte output.
- Substitutes LANES bytes per clock through a shared inverse S-box lookup, so area can be traded against latency.
- Uses valid/ready handshakes on both sides so it can buffer one block between stages.

Parameters:
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16. Any other value is a compile-time error.
- GROUPS, 16/LANES, derived (localparam, not overridable); number of substitution cycles per block.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- inValid  input  1  upstream block on state is valid
- inReady  output  1  block can accept a new state
- state  input  [0:127]  16-byte input; byte i = state[8i:8i+7], byte 0 at bits [0:7]
- outValid  output  1  stateOut holds a finished block
- outReady  input  1  downstream accepts stateOut
- stateOut  output  [0:127]  substituted block, same byte ordering as state
- busy  output  1  high in SUB or DONE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values while reset_n is low:
  - FSM = IDLE, group index = 0, buffer = 0.
  - inReady = 0, outValid = 0, busy = 0, stateOut = 0.
- inReady is registered. It goes to 1 on the first clk edge after reset_n deasserts.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - inReady = 1.
  - On an edge with inValid && inReady: capture state into the 128-bit buffer, set index = 0, clear inReady, go to SUB.
- SUB:
  - Each edge replaces buffer bytes [index*LANES .. index*LANES+LANES-1] with InvSbox(byte), using the FIPS-197 inverse S-box, then increments index.
  - On the edge that processes index = GROUPS-1, go to DONE.
  - Bytes are substituted exactly once; there is no double substitution and no skipped group.
- DONE:
  - outValid = 1; stateOut = buffer.
  - stateOut must stay stable while outValid && !outReady.
  - On an edge with outReady: clear outValid, set inReady, go to IDLE.
  - A new block cannot be accepted in the same cycle as output handoff.
- Latency: if acceptance happens on edge k, outValid is high after edge k+GROUPS. With outReady held high, the next inReady is high after edge k+GROUPS+1.
  - LANES=4: latency 4 cycles, 6 cycles per block.
  - LANES=16: latency 1 cycle, 3 cycles per block.
- stateOut is gated: it reads 0 whenever outValid = 0.
- inValid in SUB or DONE is ignored; state may change freely there.
- outReady outside DONE is ignored.
- Inputs are sampled only on the acceptance edge; the block does not depend on state after that.
- Reset asserted mid-operation (SUB or DONE):
  - Immediately abort and return to reset values.
  - No partial block is ever presented.
- The inverse S-box is a 256-entry combinational lookup, instantiated LANES times.
- No X on any output after reset.

Test Plan:
- Reset: reset_n low for 3 cycles, then high.
  - During reset: outValid=0, inReady=0, stateOut=0, busy=0.
  - One edge after release: inReady=1.
- Known vector, LANES=4: state=0x000102030405060708090a0b0c0d0e0f, inValid pulsed one cycle, outReady=1.
  - stateOut=0x52096ad53036a538bf40a39e81f3d7fb, outValid high exactly 4 cycles after acceptance.
  - Repeat with LANES=1 (latency 16) and LANES=16 (latency 1); stateOut must be identical.
- Value checks, LANES=4:
  - All bytes 0x63 -> all bytes 0x00.
  - All bytes 0xff -> all bytes 0x7d.
  - All bytes 0x7c -> all bytes 0x01.
- Backpressure: hold outReady=0 for 10 cycles after outValid rises.
  - stateOut stays constant, inReady stays 0, and a second inValid with a different state is ignored.
  - Raise outReady: one handoff, then inReady=1 on the next edge.
- Mid-operation reset: assert reset_n low 2 cycles into SUB.
  - Outputs go to 0 asynchronously (before the next edge).
  - After release, send a new block; its result is correct, with no residue from the aborted block.
- Back-to-back: stream 8 random blocks with inValid and outReady always high.
  - Results match a reference InvSubBytes model in order.
  - Spacing between blocks is GROUPS+2 cycles.

Source files
------------

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes stage: substitutes LANES bytes per clock.
// Ports:
//   clk, reset_n (async, active-low)
//   inValid/inReady/state       : upstream 128-bit block handshake
//   outValid/outReady/stateOut  : downstream block handshake (stateOut is 0 when idle)
//   busy                        : high while a block is being substituted or held
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inValid,
    output logic         inReady,
    input  logic [0:127] state,
    output logic         outValid,
    input  logic         outReady,
    output logic [0:127] stateOut,
    output logic         busy
);

    localparam int GROUPS = 16 / LANES;
    localparam int IDX_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } fsm_t;

    fsm_t             fsm;
    logic [IDX_W-1:0] idx;
    logic [0:127]     buffer;
    logic [0:127]     sub_next;
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8)
    // as a^254 (maps 0 to 0). Purely combinational 256-entry function.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] sq;
        logic [7:0] r;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Select the current group of bytes out of the buffer.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = buffer[8 * (int'(idx) * LANES + l) +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_out[g] = inv_sbox(lane_in[g]);
    end

    // Buffer with the current group replaced by its substituted bytes.
    always_comb begin
        sub_next = buffer;
        for (int l = 0; l < LANES; l++) begin
            sub_next[8 * (int'(idx) * LANES + l) +: 8] = lane_out[l];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm      <= IDLE;
            idx      <= '0;
            buffer   <= '0;
            inReady  <= 1'b0;
            outValid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    inReady <= 1'b1;
                    if (inValid && inReady) begin
                        buffer  <= state;
                        idx     <= '0;
                        inReady <= 1'b0;
                        busy    <= 1'b1;
                        fsm     <= SUB;
                    end
                end
                SUB: begin
                    buffer <= sub_next;
                    idx    <= idx + IDX_W'(1);
                    if (idx == IDX_W'(GROUPS - 1)) begin
                        outValid <= 1'b1;
                        fsm      <= DONE;
                    end
                end
                DONE: begin
                    // Handoff returns to IDLE; acceptance needs a further edge.
                    if (outReady) begin
                        outValid <= 1'b0;
                        busy     <= 1'b0;
                        inReady  <= 1'b1;
                        fsm      <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // Never expose a partially substituted buffer.
    assign stateOut = outValid ? buffer : '0;

endmodule
